// File: rtl/jpeg_pkg.sv
// jpeg_pkg: block geometry, zig-zag order and encoder FSM states.
// The decoder-side table generator derives its table from ZZ_ORDER too.
package jpeg_pkg;

    localparam int BLOCK_SIZE = 64;
    localparam int DEF_COEF_W = 8;
    localparam int DEF_RUN_W  = 4;

    localparam int ZZ_ORDER [BLOCK_SIZE] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        FINAL,
        DRAIN
    } zz_state_t;

    function automatic logic [5:0] zz_pos(input logic [5:0] k);
        return 6'(ZZ_ORDER[k]);
    endfunction

endpackage

// File: rtl/zz_pair_outreg.sv
// zz_pair_outreg: one-entry valid/ready register for a {run, coefficient} pair.
// Accepts a new pair whenever it is empty or its current pair leaves this cycle.
module zz_pair_outreg
    import jpeg_pkg::*;
#(
    parameter int COEF_W = DEF_COEF_W,
    parameter int RUN_W  = DEF_RUN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [RUN_W-1:0]  in_run,
    input  logic [COEF_W-1:0] in_coef,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [RUN_W-1:0]  out_run,
    output logic [COEF_W-1:0] out_coef
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_run   <= '0;
            out_coef  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_run  <= in_run;
                out_coef <= in_coef;
            end
        end
    end

endmodule

// File: rtl/zigzag_rle_encoder.sv
// zigzag_rle_encoder: zig-zag scans an 8x8 block into (run, coefficient) pairs.
// Define ZZ_RLE_STATS_EN to add the pair_count and block_done outputs.
module zigzag_rle_encoder
    import jpeg_pkg::*;
#(
    parameter int COEF_W = DEF_COEF_W,
    parameter int RUN_W  = DEF_RUN_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [BLOCK_SIZE*COEF_W-1:0] block_in,
    input  logic                         block_valid,
    output logic                         block_ready,
    output logic [RUN_W-1:0]             r_value,
    output logic [COEF_W-1:0]            coefficient,
    output logic                         is_new_coefficient,
    input  logic                         coef_ready
`ifdef ZZ_RLE_STATS_EN
    ,
    output logic [6:0]                   pair_count,
    output logic                         block_done
`endif
);

    localparam logic [RUN_W-1:0] MAX_RUN = '1;

    zz_state_t         state;
    zz_state_t         state_nxt;
    logic [COEF_W-1:0] blk [BLOCK_SIZE];
    logic [5:0]        k;
    logic [RUN_W-1:0]  run;
    logic              rdy_en;
    logic              accept;
    logic              can_push;
    logic              push;
    logic              last;
    logic [RUN_W-1:0]  push_run;
    logic [COEF_W-1:0] push_coef;
    logic [COEF_W-1:0] c;

    assign c      = blk[zz_pos(k)];
    assign last   = (k == 6'd63);
    assign accept = block_valid && block_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = SCAN;
            SCAN:    if (can_push && last)
                         state_nxt = (run == '0) ? DRAIN : FINAL;
            FINAL:   if (can_push) state_nxt = DRAIN;
            DRAIN:   if (is_new_coefficient && coef_ready)
                         state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // A trailing zero run is closed one slot early so the last pair hits index 63.
    always_comb begin
        block_ready = (state == IDLE) && rdy_en;
        push        = 1'b0;
        push_run    = '0;
        push_coef   = '0;
        case (state)
            SCAN: if (can_push) begin
                if (last) begin
                    push = 1'b1;
                    if (run == '0) push_coef = c;
                    else           push_run  = run - RUN_W'(1);
                end else if (c != '0) begin
                    push      = 1'b1;
                    push_run  = run;
                    push_coef = c;
                end else if (run == MAX_RUN) begin
                    push     = 1'b1;
                    push_run = MAX_RUN;
                end
            end
            FINAL: if (can_push) begin
                push      = 1'b1;
                push_coef = c;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdy_en <= 1'b0;
            k      <= '0;
            run    <= '0;
            for (int j = 0; j < BLOCK_SIZE; j++) blk[j] <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (accept) begin
                k   <= '0;
                run <= '0;
                for (int j = 0; j < BLOCK_SIZE; j++)
                    blk[j] <= block_in[j*COEF_W +: COEF_W];
            end else if (state == SCAN && can_push && !last) begin
                k   <= k + 6'd1;
                run <= (c != '0 || run == MAX_RUN) ? '0 : run + RUN_W'(1);
            end
        end
    end

    zz_pair_outreg #(
        .COEF_W (COEF_W),
        .RUN_W  (RUN_W)
    ) u_outreg (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (push),
        .in_ready  (can_push),
        .in_run    (push_run),
        .in_coef   (push_coef),
        .out_valid (is_new_coefficient),
        .out_ready (coef_ready),
        .out_run   (r_value),
        .out_coef  (coefficient)
    );

`ifdef ZZ_RLE_STATS_EN
    logic [6:0] cnt;

    assign block_done = (state == DRAIN) && is_new_coefficient && coef_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt        <= '0;
            pair_count <= '0;
        end else begin
            if (accept)    cnt <= '0;
            else if (push) cnt <= cnt + 7'd1;
            if (block_done) pair_count <= cnt;
        end
    end
`endif

endmodule

// File: tb/tb_zigzag_rle_encoder.sv
// tb_zigzag_rle_encoder: randomized and directed checks of zigzag_rle_encoder
// against a queue-based reference scan and a decoder-style block rebuild.
module tb_zigzag_rle_encoder;

    localparam int CW = 8;
    localparam int RW = 4;

    typedef struct packed {
        logic [RW-1:0] r;
        logic [CW-1:0] c;
    } pair_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [64*CW-1:0] block_in;
    logic            block_valid;
    logic            block_ready;
    logic [RW-1:0]   r_value;
    logic [CW-1:0]   coefficient;
    logic            is_new_coefficient;
    logic            coef_ready;
`ifdef ZZ_RLE_STATS_EN
    logic [6:0]      pair_count;
    logic            block_done;
`endif

    zigzag_rle_encoder #(.COEF_W(CW), .RUN_W(RW)) dut (
        .clk                (clk),
        .rst                (rst),
        .block_in           (block_in),
        .block_valid        (block_valid),
        .block_ready        (block_ready),
        .r_value            (r_value),
        .coefficient        (coefficient),
        .is_new_coefficient (is_new_coefficient),
        .coef_ready         (coef_ready)
`ifdef ZZ_RLE_STATS_EN
        ,
        .pair_count         (pair_count),
        .block_done         (block_done)
`endif
    );

    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_bad = 0;
    int    zz [64];
    pair_t exp_q [$];
    pair_t got_q [$];
    bit    exp_final;
    int    first_n;
    int    last_n;
    bit    rdy_bad;
    bit    hold_bad;
    logic  ready_after;

    // Zig-zag order built by walking the anti-diagonals of the 8x8 grid.
    function automatic void build_zz();
        int idx = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 0) begin
                for (int row = hi; row >= lo; row--) begin
                    zz[idx] = row * 8 + (s - row);
                    idx++;
                end
            end else begin
                for (int row = lo; row <= hi; row++) begin
                    zz[idx] = row * 8 + (s - row);
                    idx++;
                end
            end
        end
    endfunction

    function automatic void model(input logic [64*CW-1:0] b);
        int pending = 0;
        logic [CW-1:0] v;
        exp_q.delete();
        exp_final = 1'b0;
        for (int k = 0; k < 64; k++) begin
            v = b[zz[k]*CW +: CW];
            if (k == 63) begin
                if (pending == 0) begin
                    exp_q.push_back({4'd0, v});
                end else begin
                    exp_q.push_back({4'(pending - 1), 8'd0});
                    exp_q.push_back({4'd0, v});
                    exp_final = 1'b1;
                end
            end else if (v != 0 || pending == 15) begin
                exp_q.push_back({4'(pending), v});
                pending = 0;
            end else begin
                pending++;
            end
        end
    endfunction

    function automatic logic [64*CW-1:0] decode_got();
        logic [64*CW-1:0] b = '0;
        int p = -1;
        foreach (got_q[i]) begin
            p += int'(got_q[i].r) + 1;
            if (p >= 0 && p < 64) b[zz[p]*CW +: CW] = got_q[i].c;
        end
        return b;
    endfunction

    function automatic int place_sum();
        int s = 0;
        foreach (got_q[i]) s += int'(got_q[i].r) + 1;
        return s;
    endfunction

    function automatic int stream_diffs();
        int d = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) d++;
        if (got_q.size() > exp_q.size()) d += got_q.size() - exp_q.size();
        return d;
    endfunction

    task automatic send_block(input logic [64*CW-1:0] b, output bit ok);
        int n = 0;
        @(negedge clk);
        while (block_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        ok = (block_ready === 1'b1);
        if (!ok) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_wait: block_ready=%b, required 1 within 100 cycles", block_ready);
            return;
        end
        block_in    = b;
        block_valid = 1'b1;
        @(negedge clk);
        block_valid = 1'b0;
        block_in    = {16{$urandom()}};
    endtask

    // mode 0: always ready, 1: stall 5 cycles on first pair, 2: random ready
    task automatic run_block(input logic [64*CW-1:0] b, input int mode);
        bit ok;
        bit done = 0;
        bit stalled = 0;
        int stall_left = 0;
        int sum = 0;
        int n = 1;
        model(b);
        got_q.delete();
        first_n  = -1;
        last_n   = -1;
        rdy_bad  = 0;
        hold_bad = 0;
        send_block(b, ok);
        if (!ok) return;
        while (!done && n < 600) begin
            case (mode)
                0: coef_ready = 1'b1;
                1: begin
                    if (is_new_coefficient === 1'b1 && !stalled) begin
                        stalled    = 1;
                        stall_left = 5;
                    end
                    if (stall_left > 0) begin
                        coef_ready = 1'b0;
                        stall_left--;
                        if (is_new_coefficient !== 1'b1 ||
                            {r_value, coefficient} !== exp_q[0])
                            hold_bad = 1;
                    end else begin
                        coef_ready = 1'b1;
                    end
                end
                default: coef_ready = ($urandom_range(0, 2) != 0);
            endcase
            if (is_new_coefficient === 1'b1 && first_n < 0) first_n = n;
            if (block_ready !== 1'b0) rdy_bad = 1;
            if (is_new_coefficient === 1'b1 && coef_ready) begin
                got_q.push_back({r_value, coefficient});
                sum += int'(r_value) + 1;
                if (sum >= 64) begin
                    done   = 1;
                    last_n = n;
                end
            end
            @(negedge clk);
            n++;
        end
        coef_ready  = 1'b1;
        ready_after = block_ready;
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL block_timeout: placement sum %0d, required 64", sum);
        end
    endtask

    function automatic logic [64*CW-1:0] ramp_block();
        logic [64*CW-1:0] b;
        for (int j = 0; j < 64; j++) b[j*CW +: CW] = 8'(j + 1);
        return b;
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({block_ready, is_new_coefficient, r_value, coefficient} !== 14'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got rdy=%b new=%b r=%0d c=%0d, required all 0",
                     block_ready, is_new_coefficient, r_value, coefficient);
        end
        rst = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (block_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: got %b, required 1", block_ready);
        end
    endtask

    task automatic test_all_zero();
        logic [64*CW-1:0] b = '0;
        run_block(b, 0);
        n_cmp++;
        if (got_q.size() !== 5) begin
            n_bad++;
            $display("FAIL zero_count: got %0d pairs, required 5", got_q.size());
        end
        n_cmp++;
        if (stream_diffs() != 0) begin
            n_bad++;
            $display("FAIL zero_stream: %0d pairs differ from model", stream_diffs());
        end
        n_cmp++;
        if (first_n != int'(exp_q[0].r) + 2) begin
            n_bad++;
            $display("FAIL zero_first_latency: got %0d, required %0d", first_n, exp_q[0].r + 2);
        end
        n_cmp++;
        if (last_n != 65 + int'(exp_final)) begin
            n_bad++;
            $display("FAIL zero_last_latency: got %0d, required %0d", last_n, 65 + exp_final);
        end
        n_cmp++;
        if (rdy_bad || ready_after !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_ready: busy_high=%0d after=%b, required 0 and 1", rdy_bad, ready_after);
        end
    endtask

    task automatic test_dc_only();
        logic [64*CW-1:0] b = '0;
        b[7:0] = 8'd5;
        run_block(b, 0);
        n_cmp++;
        if (got_q.size() !== 6 || stream_diffs() != 0) begin
            n_bad++;
            $display("FAIL dc_stream: got %0d pairs, %0d differ, required 6 matching",
                     got_q.size(), stream_diffs());
        end
        n_cmp++;
        if (got_q.size() > 0 && got_q[0] !== {4'd0, 8'd5}) begin
            n_bad++;
            $display("FAIL dc_first: got r=%0d c=%0d, required r=0 c=5", got_q[0].r, got_q[0].c);
        end
    endtask

    task automatic test_ramp();
        logic [64*CW-1:0] b = ramp_block();
        run_block(b, 0);
        n_cmp++;
        if (got_q.size() !== 64 || stream_diffs() != 0) begin
            n_bad++;
            $display("FAIL ramp_stream: got %0d pairs, %0d differ, required 64 matching",
                     got_q.size(), stream_diffs());
        end
        n_cmp++;
        if (first_n != 2 || last_n != 65) begin
            n_bad++;
            $display("FAIL ramp_latency: got first=%0d last=%0d, required 2 and 65", first_n, last_n);
        end
`ifdef ZZ_RLE_STATS_EN
        n_cmp++;
        if (pair_count !== 7'd64) begin
            n_bad++;
            $display("FAIL ramp_pair_count: got %0d, required 64", pair_count);
        end
`endif
    endtask

    task automatic test_last_only();
        logic [64*CW-1:0] b = '0;
        b[63*CW +: CW] = 8'h7F;
        run_block(b, 0);
        n_cmp++;
        if (got_q.size() !== 5 || stream_diffs() != 0) begin
            n_bad++;
            $display("FAIL last_stream: got %0d pairs, %0d differ, required 5 matching",
                     got_q.size(), stream_diffs());
        end
        n_cmp++;
        if (decode_got() !== b) begin
            n_bad++;
            $display("FAIL last_rebuild: got %h, required %h", decode_got(), b);
        end
    endtask

    task automatic test_backpressure();
        logic [64*CW-1:0] b = ramp_block();
        run_block(b, 1);
        n_cmp++;
        if (hold_bad) begin
            n_bad++;
            $display("FAIL bp_hold: pair not held at r=%0d c=%0d during stall",
                     exp_q[0].r, exp_q[0].c);
        end
        n_cmp++;
        if (got_q.size() !== 64 || stream_diffs() != 0) begin
            n_bad++;
            $display("FAIL bp_stream: got %0d pairs, %0d differ, required 64 matching",
                     got_q.size(), stream_diffs());
        end
        n_cmp++;
        if (rdy_bad || ready_after !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_ready: busy_high=%0d after=%b, required 0 and 1", rdy_bad, ready_after);
        end
    endtask

    task automatic test_reset_midblock();
        logic [64*CW-1:0] b = ramp_block();
        bit ok;
        int n = 0;
        model(b);
        got_q.delete();
        coef_ready = 1'b1;
        send_block(b, ok);
        if (!ok) return;
        while (got_q.size() < 10 && n < 200) begin
            if (is_new_coefficient === 1'b1) got_q.push_back({r_value, coefficient});
            if (got_q.size() < 10) begin
                @(negedge clk);
                n++;
            end
        end
        n_cmp++;
        if (got_q.size() != 10 || stream_diffs() != 54) begin
            n_bad++;
            $display("FAIL rst_prefix: got %0d pairs, %0d diffs, required 10 and 54",
                     got_q.size(), stream_diffs());
        end
        @(negedge clk);
        coef_ready = 1'b0;
        rst        = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_cmp++;
        if (is_new_coefficient !== 1'b0 || block_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_clear: got new=%b rdy=%b, required 0 0",
                     is_new_coefficient, block_ready);
        end
        @(negedge clk);
        n_cmp++;
        if (block_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL rst_mid_idle: got rdy=%b, required 1", block_ready);
        end
        coef_ready = 1'b1;
        b = '0;
        run_block(b, 0);
        n_cmp++;
        if (got_q.size() !== 5 || stream_diffs() != 0) begin
            n_bad++;
            $display("FAIL rst_after_zero: got %0d pairs, %0d differ, required 5 matching",
                     got_q.size(), stream_diffs());
        end
    endtask

    task automatic test_random();
        logic [64*CW-1:0] b;
        for (int t = 0; t < 24; t++) begin
            int dens = $urandom_range(1, 8);
            for (int j = 0; j < 64; j++)
                b[j*CW +: CW] = ($urandom_range(0, dens) == 0) ? 8'($urandom()) : 8'd0;
            run_block(b, (t % 3 == 0) ? 0 : 2);
            n_cmp++;
            if (stream_diffs() != 0) begin
                n_bad++;
                $display("FAIL rand%0d_stream: %0d pairs differ, got %0d want %0d",
                         t, stream_diffs(), got_q.size(), exp_q.size());
            end
            n_cmp++;
            if (decode_got() !== b || place_sum() != 64 ||
                got_q.size() == 0 || got_q[got_q.size()-1].r !== 4'd0) begin
                n_bad++;
                $display("FAIL rand%0d_rebuild: sum=%0d got %h want %h",
                         t, place_sum(), decode_got(), b);
            end
            n_cmp++;
            if (rdy_bad || ready_after !== 1'b1) begin
                n_bad++;
                $display("FAIL rand%0d_ready: busy_high=%0d after=%b, required 0 and 1",
                         t, rdy_bad, ready_after);
            end
        end
    endtask

    initial begin
        rst         = 1'b0;
        block_valid = 1'b0;
        block_in    = '0;
        coef_ready  = 1'b1;
        build_zz();
        test_reset();
        test_all_zero();
        test_dc_only();
        test_ramp();
        test_last_only();
        test_backpressure();
        test_reset_midblock();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
